// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, latches the ALU result
// and hands it to the transmitter. Define INTERFACE_TIMEOUT_EN to abandon frames stalled between bytes.
module uart_alu_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy
);

  localparam logic [2:0] S_WAIT_A  = 3'd0;
  localparam logic [2:0] S_WAIT_B  = 3'd1;
  localparam logic [2:0] S_WAIT_OP = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;

  logic [2:0] state;
  logic       rx_done_d;
  logic       tx_done_d;
  logic       rx_accept;
  logic       tx_fin;
  logic       timeout_hit;

  // Both completion flags are levels; only their rising edges count as events.
  assign rx_accept = i_rx_done & ~rx_done_d;
  assign tx_fin    = i_tx_done & ~tx_done_d;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rx_done_d <= 1'b0;
      tx_done_d <= 1'b0;
    end else begin
      rx_done_d <= i_rx_done;
      tx_done_d <= i_tx_done;
    end
  end

`ifdef INTERFACE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] timeout_cnt;
  logic             mid_frame;

  assign mid_frame   = (state == S_WAIT_B) || (state == S_WAIT_OP);
  assign timeout_hit = mid_frame && (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles between bytes of a partial frame; any accept restarts the wait.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      timeout_cnt <= '0;
    end else if (mid_frame && !rx_accept && !timeout_hit) begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end else begin
      timeout_cnt <= '0;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // The opcode only uses the low bits of the third byte.
  logic unused_rx_bits;
  assign unused_rx_bits = &{1'b0, i_rx_data[NB_DATA-1:NB_OP]};

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= S_WAIT_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        S_WAIT_A: begin
          if (rx_accept) begin
            o_data_a <= i_rx_data;
            state    <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (rx_accept) begin
            o_data_b <= i_rx_data;
            state    <= S_WAIT_OP;
          end else if (timeout_hit) begin
            state <= S_WAIT_A;
          end
        end
        S_WAIT_OP: begin
          if (rx_accept) begin
            o_op  <= i_rx_data[NB_OP-1:0];
            state <= S_COMPUTE;
          end else if (timeout_hit) begin
            state <= S_WAIT_A;
          end
        end
        // Operands settled during the previous cycle, so the ALU output is stable here.
        S_COMPUTE: begin
          o_tx_data <= i_alu_result;
          o_busy    <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          o_tx_start <= 1'b1;
          state      <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (tx_fin) begin
            o_busy <= 1'b0;
            state  <= S_WAIT_A;
          end
        end
        default: state <= S_WAIT_A;
      endcase
    end
  end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Downstream consumer of the UART receiver's byte stream.
- Assembles three received bytes into operand A, operand B and opcode, then presents them to the combinational ALU.
- Captures the ALU result and hands it to the UART transmitter as one byte.
- Sits between the receiver (rx_data_out/rx_done), the ALU, and the transmitter (data plus start/done handshake).

Parameters:
- NB_DATA, 8, width of each received byte, each operand, the result and the tx byte.
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles; used only when INTERFACE_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_rx_data  input  NB_DATA  byte from the receiver; valid while i_rx_done is high.
- i_rx_done  input  1  receiver completion flag (level); a byte is accepted on its rising edge.
- i_alu_result  input  NB_DATA  combinational ALU output.
- i_tx_done  input  1  transmitter completion flag (level); completion is its rising edge.
- o_data_a  output  NB_DATA  operand A to the ALU.
- o_data_b  output  NB_DATA  operand B to the ALU.
- o_op  output  NB_OP  opcode to the ALU.
- o_tx_data  output  NB_DATA  result byte to the transmitter.
- o_tx_start  output  1  one-cycle pulse requesting transmission.
- o_busy  output  1  high from result capture until transmission completes.

Behaviour:
- Reset: synchronous; i_rst high at a clk edge forces state S_WAIT_A.
  - All outputs go to 0.
  - Edge-detect registers rx_done_d and tx_done_d go to 0.
  - Timeout counter goes to 0.
  - Applies in any state, including mid-frame and mid-transmission. A partial frame is discarded.
- Edge detection: rx_done_d and tx_done_d register the previous cycle's input.
  - rx_accept = i_rx_done & ~rx_done_d.
  - tx_fin = i_tx_done & ~tx_done_d.
  - A flag held high for many cycles yields exactly one event.
- State machine, all transitions on the clk edge:
  - S_WAIT_A: on rx_accept, o_data_a <= i_rx_data, go to S_WAIT_B.
  - S_WAIT_B: on rx_accept, o_data_b <= i_rx_data, go to S_WAIT_OP.
  - S_WAIT_OP: on rx_accept, o_op <= i_rx_data[NB_OP-1:0], go to S_COMPUTE. Upper byte bits are ignored.
  - S_COMPUTE: exactly one cycle. o_tx_data <= i_alu_result, o_busy <= 1, go to S_SEND. Operands have been stable for at least one full cycle before capture.
  - S_SEND: exactly one cycle. o_tx_start = 1 for this cycle only, go to S_WAIT_TX.
  - S_WAIT_TX: on tx_fin, o_busy <= 0, go to S_WAIT_A.
- Latency:
  - Third-byte accept edge to o_tx_data valid: 1 cycle.
  - Third-byte accept edge to o_tx_start high: 2 cycles.
- Operand retention:
  - o_data_a, o_data_b and o_op hold their values until overwritten by the next frame.
  - The ALU output therefore stays meaningful after transmission.
- Bytes arriving in S_COMPUTE, S_SEND or S_WAIT_TX are dropped; operands are unchanged.
- Edge-detect registers update in every state. A rx_done rising during S_WAIT_TX and still high on return to S_WAIT_A is not accepted, because no new edge occurs.
- A tx_fin edge in any state other than S_WAIT_TX is ignored.
- o_tx_data is not cleared after transmission; it holds the last result.

Optional Feature:
- Macro: INTERFACE_TIMEOUT_EN.
- When defined:
  - A counter runs in S_WAIT_B and S_WAIT_OP.
  - It clears on every rx_accept and on entry to S_WAIT_A.
  - When it reaches TIMEOUT_CYCLES-1 without an accept, the FSM returns to S_WAIT_A next cycle and the partial frame is abandoned.
  - Already-latched operand registers keep their values.
  - The counter does not run in S_WAIT_A, S_COMPUTE, S_SEND or S_WAIT_TX.
- When undefined: no counter is synthesized; S_WAIT_B and S_WAIT_OP wait indefinitely.

Test Plan:
- Basic frame: bytes 0x05, 0x03, 0x20 with rx_done pulses; ALU model returns A+B.
  - o_data_a=0x05, o_data_b=0x03, o_op=6'h20.
  - o_tx_data=0x08 one cycle after the third accept.
  - o_tx_start high for exactly 1 cycle, one cycle later.
  - o_busy high until the i_tx_done rising edge.
- Held flag: i_rx_done held high 50 cycles with byte 0xAA → only o_data_a=0xAA captured; state remains S_WAIT_B.
- Busy drop: send frame 0x0F, 0x01, 0x20, then byte 0x77 during S_WAIT_TX.
  - 0x77 is ignored.
  - After tx_fin, the next frame 0x10, 0x02, 0x22 yields operands 0x10/0x02/0x22 with no shift.
- Reset mid-frame: accept 0x11, 0x22, then pulse i_rst one cycle.
  - All outputs 0, state S_WAIT_A.
  - Next frame 0x01, 0x02, 0x20 is processed normally.
- Opcode truncation: third byte 0xE4 → o_op=6'h24.
- Timeout (INTERFACE_TIMEOUT_EN, TIMEOUT_CYCLES=100): accept 0x33, wait 100 cycles, then send 0x44, 0x55, 0x20.
  - Frame restarts: o_data_a=0x44, o_data_b=0x55.
  - Without the macro, the same stimulus gives A=0x33, B=0x44, op=0x15.
